// File: rtl/uart_cpld_pkg.sv
// Shared types and helpers for the CPLD UART bus controller.
package uart_cpld_pkg;

    // Bus-cycle states of the controller.
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_LOW   = 3'd1,
        S_RD_DONE  = 3'd2,
        S_WR_SETUP = 3'd3,
        S_WR_LOW   = 3'd4,
        S_WR_HOLD  = 3'd5,
        S_WR_SETTLE= 3'd6,
        S_WR_WAIT  = 3'd7
    } state_t;

    // Level of an inactive (deasserted) active-low strobe.
    localparam logic STROBE_OFF = 1'b1;

    // Ceiling log2 for sizing pointers and counters at elaboration time.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output.
// Push when full and pop when empty are ignored; DEPTH is a power of 2
// so the pointers wrap by natural overflow.
module sync_fifo
    import uart_cpld_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [WIDTH-1:0]        din,
    input  logic                    pop,
    output logic [WIDTH-1:0]        dout,
    output logic                    full,
    output logic                    empty,
    output logic [clog2(DEPTH):0]   level
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_level == LW'(DEPTH));
    assign empty  = (r_level == '0);
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;
    assign dout   = r_mem[r_rd_ptr];
    assign level  = r_level;

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/uart_cpld_ctrl.sv
// Clocked bus-cycle controller for the CPLD UART sharing the RAM1 data bus.
// Reads have priority over writes; RAM1 is held disabled so the bus
// belongs to the UART. Streams: a transfer happens on valid & ready.
module uart_cpld_ctrl
    import uart_cpld_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int TX_DEPTH   = 4,
    parameter int RX_DEPTH   = 4,
    parameter int PULSE_CYC  = 2,
    parameter int SETTLE_CYC = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_valid,
    output logic                      tx_ready,
    output logic [DATA_W-1:0]         rx_data,
    output logic                      rx_valid,
    input  logic                      rx_ready,
    input  logic                      uart_tbre,
    input  logic                      uart_tsre,
    input  logic                      uart_data_ready,
    input  logic [DATA_W-1:0]         uart_din,
    output logic [DATA_W-1:0]         uart_dout,
    output logic                      uart_doe,
    output logic                      rdn,
    output logic                      wrn,
    output logic                      ram1_en,
    output logic                      ram1_oe,
    output logic                      ram1_we,
    output logic [clog2(TX_DEPTH):0]  tx_level,
    output logic [clog2(RX_DEPTH):0]  rx_level,
    output logic                      busy,
    output state_t                    dbg_state
);

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] PULSE_LAST  = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_tbre_m, r_tbre_s;
    logic                r_tsre_m, r_tsre_s;
    logic                r_dr_m, r_dr_s;
    logic                r_rdn, r_wrn, r_doe;
    logic [DATA_W-1:0]   r_dout;
    logic                w_tx_full, w_tx_empty, w_tx_pop;
    logic                w_rx_full, w_rx_empty, w_rx_push;
    logic [DATA_W-1:0]   w_tx_head;

    assign tx_ready  = ~w_tx_full;
    assign rx_valid  = ~w_rx_empty;
    assign rdn       = r_rdn;
    assign wrn       = r_wrn;
    assign uart_doe  = r_doe;
    assign uart_dout = r_dout;
    assign ram1_en   = STROBE_OFF;
    assign ram1_oe   = STROBE_OFF;
    assign ram1_we   = STROBE_OFF;
    assign busy      = (r_state != S_IDLE);
    assign dbg_state = r_state;

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid & ~w_tx_full),
        .din   (tx_data),
        .pop   (w_tx_pop),
        .dout  (w_tx_head),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .level (tx_level)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .din   (uart_din),
        .pop   (rx_valid & rx_ready),
        .dout  (rx_data),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .level (rx_level)
    );

    // Two-flop synchronisers for the asynchronous CPLD status lines.
    always_ff @(posedge clk) begin
        if (!rst) begin
            {r_tbre_m, r_tbre_s} <= 2'b00;
            {r_tsre_m, r_tsre_s} <= 2'b00;
            {r_dr_m, r_dr_s}     <= 2'b00;
        end else begin
            r_tbre_m <= uart_tbre;
            r_tbre_s <= r_tbre_m;
            r_tsre_m <= uart_tsre;
            r_tsre_s <= r_tsre_m;
            r_dr_m   <= uart_data_ready;
            r_dr_s   <= r_dr_m;
        end
    end

    // Next-state logic; the TX head is popped onto the bus as WR_SETUP is entered.
    always_comb begin
        w_state_next = r_state;
        w_tx_pop     = 1'b0;
        w_rx_push    = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A full RX FIFO leaves data_ready pending; the CPLD keeps the byte.
                if (r_dr_s && !w_rx_full) begin
                    w_state_next = S_RD_LOW;
                end else if (!w_tx_empty) begin
                    w_state_next = S_WR_SETUP;
                    w_tx_pop     = 1'b1;
                end
            end
            S_RD_LOW: begin
                if (r_cnt == PULSE_LAST) begin
                    w_rx_push    = 1'b1;
                    w_state_next = S_RD_DONE;
                end
            end
            // Wait for data_ready to drop so one byte is never read twice.
            S_RD_DONE:   if (!r_dr_s) w_state_next = S_IDLE;
            S_WR_SETUP:  w_state_next = S_WR_LOW;
            S_WR_LOW:    if (r_cnt == PULSE_LAST) w_state_next = S_WR_HOLD;
            S_WR_HOLD:   w_state_next = S_WR_SETTLE;
            // tbre/tsre are stale right after the write; let them settle first.
            S_WR_SETTLE: if (r_cnt == SETTLE_LAST) w_state_next = S_WR_WAIT;
            S_WR_WAIT:   if (r_tbre_s && r_tsre_s) w_state_next = S_IDLE;
            default:     w_state_next = S_IDLE;
        endcase
    end

    // State register, dwell counter and glitch-free registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rdn   <= STROBE_OFF;
            r_wrn   <= STROBE_OFF;
            r_doe   <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + CNT_W'(1);
            r_rdn   <= (w_state_next == S_RD_LOW) ? ~STROBE_OFF : STROBE_OFF;
            r_wrn   <= (w_state_next == S_WR_LOW) ? ~STROBE_OFF : STROBE_OFF;
            r_doe   <= (w_state_next == S_WR_SETUP) || (w_state_next == S_WR_LOW) ||
                       (w_state_next == S_WR_HOLD);
            if (w_tx_pop) r_dout <= w_tx_head;
        end
    end

endmodule

// File: tb/tb_uart_cpld_ctrl.sv
// Self-checking bench for uart_cpld_ctrl with a behavioural CPLD model.
module tb_uart_cpld_ctrl;
    import uart_cpld_pkg::*;

    localparam int DW  = 8;
    localparam int TXD = 4;
    localparam int RXD = 4;
    localparam int PC  = 2;
    localparam int SC  = 3;
    localparam int TX_HOLD_CYC = 20;
    localparam int RX_GAP_CYC  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          u_tbre = 1'b1, u_tsre = 1'b1;
    logic          dr_m = 1'b0, dr_force = 1'b0;
    logic [DW-1:0] u_din = '0;
    logic [DW-1:0] uart_dout;
    logic          uart_doe, rdn, wrn, ram1_en, ram1_oe, ram1_we, busy;
    logic [2:0]    tx_level, rx_level;
    state_t        dbg_state;

    uart_cpld_ctrl #(
        .DATA_W(DW), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .PULSE_CYC(PC), .SETTLE_CYC(SC)
    ) dut (
        .clk(clk), .rst(rst),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .uart_tbre(u_tbre), .uart_tsre(u_tsre), .uart_data_ready(dr_m | dr_force),
        .uart_din(u_din), .uart_dout(uart_dout), .uart_doe(uart_doe),
        .rdn(rdn), .wrn(wrn),
        .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .tx_level(tx_level), .rx_level(rx_level), .busy(busy), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;
    logic [DW-1:0] exp_tx[$];
    logic [DW-1:0] exp_rx[$];
    logic [DW-1:0] rx_src_q[$];
    bit  chk_en = 0;
    int  cyc = 0, tx_cnt = 0, rx_cnt = 0;
    bit  pend_push = 0, pend_pop = 0;
    logic [DW-1:0] pend_data = '0;
    logic prev_rdn = 1'b1, prev_wrn = 1'b1, prev_doe = 1'b0;
    int  wr_len = 0, rd_len = 0, n_writes = 0, n_reads = 0;
    int  t_wr_fall = 0, t_rd_fall = 0;
    int  tx_hold = 0, rx_gap = 0, stalls = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- compare process + CPLD model ----------------
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst) begin
                tx_cnt = 0; rx_cnt = 0; pend_push = 0; pend_pop = 0;
                exp_tx.delete(); exp_rx.delete();
                wr_len = 0; rd_len = 0;
                prev_rdn = 1'b1; prev_wrn = 1'b1; prev_doe = 1'b0;
            end else if (chk_en) begin
                cyc++;
                // TX occupancy: pushes land next edge, the head leaves when doe rises.
                if (pend_push) begin tx_cnt++; exp_tx.push_back(pend_data); end
                if (uart_doe && !prev_doe) tx_cnt--;
                chk("tx_level", tx_level, tx_cnt);
                chk("tx_ready", tx_ready, tx_cnt < TXD);
                // RX occupancy: a byte lands when rdn returns high.
                if (pend_pop) rx_cnt--;
                if (rdn && !prev_rdn) rx_cnt++;
                chk("rx_level", rx_level, rx_cnt);
                chk("rx_valid", rx_valid, rx_cnt != 0);
                if (rx_valid && rx_ready) begin
                    if (exp_rx.size() > 0) chk("rx_data", rx_data, exp_rx.pop_front());
                    else chk("rx_unexpected_pop", 1, 0);
                end
                // Bus invariants.
                chk("strobes_overlap", !rdn && !wrn, 0);
                chk("doe_during_read", uart_doe && !rdn, 0);
                chk("ram1_disabled", {ram1_en, ram1_oe, ram1_we}, 3'b111);
                // Write cycle shape.
                if (!wrn) begin
                    wr_len++;
                    chk("wr_doe_low", uart_doe, 1);
                    if (exp_tx.size() > 0) chk("wr_dout", uart_dout, exp_tx[0]);
                    else chk("wr_unexpected", 1, 0);
                end
                if (!wrn && prev_wrn) begin
                    chk("wr_doe_setup", prev_doe, 1);
                    t_wr_fall = cyc;
                end
                if (wrn && !prev_wrn) begin
                    chk("wr_pulse_len", wr_len, PC);
                    chk("wr_doe_hold", uart_doe, 1);
                    if (exp_tx.size() > 0) void'(exp_tx.pop_front());
                    n_writes++;
                    wr_len = 0;
                end
                // Read cycle shape.
                if (!rdn) rd_len++;
                if (!rdn && prev_rdn) begin n_reads++; t_rd_fall = cyc; end
                if (rdn && !prev_rdn) begin
                    chk("rd_pulse_len", rd_len, PC);
                    rd_len = 0;
                end
                if (tx_hold > 0) chk("busy_until_tx_empty", busy, 1);
                pend_push = tx_valid && tx_ready;
                pend_data = tx_data;
                pend_pop  = rx_valid && rx_ready;
                // CPLD transmitter: busy for a while after each write strobe.
                if (tx_hold > 0) begin
                    tx_hold--;
                    if (tx_hold == 0) begin u_tbre = 1'b1; u_tsre = 1'b1; end
                end
                if (wrn && !prev_wrn) begin
                    u_tbre = 1'b0; u_tsre = 1'b0; tx_hold = TX_HOLD_CYC;
                end
                // CPLD receiver: offer bytes, drop data_ready 2 cycles into rdn low.
                if (!rdn && rd_len == PC && dr_m) begin
                    dr_m = 1'b0;
                    exp_rx.push_back(rx_src_q.pop_front());
                    rx_gap = RX_GAP_CYC;
                end else if (rx_gap > 0) begin
                    rx_gap--;
                end else if (!dr_m && rx_src_q.size() > 0) begin
                    dr_m = 1'b1;
                    u_din = rx_src_q[0];
                end
                prev_rdn = rdn; prev_wrn = wrn; prev_doe = uart_doe;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic sync_drive();
        @(posedge clk);
        #1;
    endtask

    // Call aligned just after a rising edge; returns aligned after the push edge.
    task automatic push_tx(input logic [DW-1:0] b);
        bit ok = 0;
        tx_valid = 1'b1;
        tx_data  = b;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            ok = tx_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
        end
        tx_valid = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic pop_rx(input int n);
        rx_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int quiet = 0;
        for (int i = 0; i < bound && quiet < 4; i++) begin
            @(negedge clk);
            if (!busy && tx_hold == 0 && rx_src_q.size() == 0 && !dr_m && tx_level == 0)
                quiet++;
            else
                quiet = 0;
        end
        chk("idle_reached", quiet >= 4, 1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int base;
        int t_first;
        bit seen;

        // Reset with stimulus active.
        rst = 1'b0; tx_valid = 1'b1; tx_data = 8'h77; dr_force = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("rst_rdn", rdn, 1);
        chk("rst_wrn", wrn, 1);
        chk("rst_doe", uart_doe, 0);
        chk("rst_dout", uart_dout, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_ready", tx_ready, 1);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_level", rx_level, 0);
        chk("rst_busy", busy, 0);
        tx_valid = 1'b0; dr_force = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        chk_en = 1;
        repeat (3) sync_drive();

        // Single write with latency pinned: wrn falls in the 3rd cycle after the push.
        push_tx(8'h5A);
        @(negedge clk);
        chk("lat_idle_busy", busy, 0);
        chk("lat_idle_wrn", wrn, 1);
        @(negedge clk);
        chk("lat_setup_wrn", wrn, 1);
        chk("lat_setup_doe", uart_doe, 1);
        chk("lat_setup_dout", uart_dout, 8'h5A);
        @(negedge clk);
        chk("lat_low_wrn", wrn, 0);
        wait_idle(300);
        chk("wr1_count", n_writes, 1);

        // Single read.
        sync_drive();
        rx_src_q.push_back(8'hC3);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = rx_valid;
        end
        chk("rd1_valid", seen, 1);
        chk("rd1_data", rx_data, 8'hC3);
        chk("rd1_level", rx_level, 1);
        repeat (20) @(negedge clk);
        chk("rd1_single_read", n_reads, 1);
        sync_drive();
        pop_rx(1);
        wait_idle(300);
        chk("rd1_drained", rx_valid, 0);

        // RX full backpressure: five bytes offered, only four fit.
        base = n_reads;
        for (int b = 1; b <= 5; b++) rx_src_q.push_back(DW'(b));
        repeat (100) @(negedge clk);
        chk("full_reads4", n_reads - base, 4);
        chk("full_level", rx_level, 4);
        chk("full_dr_pending", dr_m, 1);
        chk("full_idle", busy, 0);
        chk("full_head", rx_data, 8'h01);
        sync_drive();
        pop_rx(1);
        repeat (60) @(negedge clk);
        chk("full_reads5", n_reads - base, 5);
        chk("full_level_refill", rx_level, 4);
        sync_drive();
        pop_rx(4);
        wait_idle(300);
        chk("full_all_popped", exp_rx.size(), 0);
        chk("full_empty", rx_level, 0);

        // Arbitration: read pending alongside TX byte 0xAA is served first.
        sync_drive();
        push_tx(8'h11);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = (tx_hold > 0);
        end
        chk("arb_wr1_started", seen, 1);
        t_first = t_wr_fall;
        sync_drive();
        rx_src_q.push_back(8'h3C);
        push_tx(8'hAA);
        wait_idle(400);
        chk("arb_rd_after_wr1", t_rd_fall > t_first, 1);
        chk("arb_rd_before_wr2", t_rd_fall < t_wr_fall, 1);
        chk("arb_rx_level", rx_level, 1);
        chk("arb_rx_data", rx_data, 8'h3C);
        sync_drive();
        pop_rx(1);
        repeat (4) @(negedge clk);

        // TX wrap: nine bytes through a four-deep FIFO.
        base = n_writes;
        stalls = 0;
        sync_drive();
        for (int i = 0; i < 9; i++) push_tx(DW'(8'h10 + i));
        wait_idle(1500);
        chk("wrap_writes", n_writes - base, 9);
        chk("wrap_stalled", stalls > 0, 1);
        chk("wrap_all_written", exp_tx.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_cpld_ctrl.md
Name: uart_cpld_ctrl

Overview:
- Parametrised controller for the CPLD-hosted UART on the shared RAM1/UART data bus.
- Replaces combinational rdn/wrn gating with a clocked bus-cycle state machine.
- Adds independent TX and RX FIFOs with valid/ready streams and synchronised CPLD status inputs.
- Holds RAM1 disabled so the data bus is owned by the UART.

Parameters:
DATA_W, 8, UART data width (bits)
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
RX_DEPTH, 4, RX FIFO entries (power of 2, >=2)
PULSE_CYC, 2, clk cycles rdn/wrn held low (>=1)
SETTLE_CYC, 3, cycles after a write before tbre/tsre are sampled (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-low
tx_data  in  DATA_W  byte to transmit
tx_valid  in  1  tx_data valid
tx_ready  out  1  TX FIFO not full
rx_data  out  DATA_W  head of RX FIFO
rx_valid  out  1  RX FIFO not empty
rx_ready  in  1  consumer pops RX head
uart_tbre  in  1  CPLD transmit buffer empty (async)
uart_tsre  in  1  CPLD transmit shift register empty (async)
uart_data_ready  in  1  CPLD received byte available (async)
uart_din  in  DATA_W  data bus, read side
uart_dout  out  DATA_W  data bus, write side
uart_doe  out  1  drive enable for uart_dout (top-level tristate)
rdn  out  1  CPLD read strobe, active-low
wrn  out  1  CPLD write strobe, active-low
ram1_en, ram1_oe, ram1_we  out  1 each  tied 1 (RAM1 disabled)
tx_level  out  clog2(TX_DEPTH)+1  TX FIFO occupancy
rx_level  out  clog2(RX_DEPTH)+1  RX FIFO occupancy
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (rst=0 at a clk edge):
  - FSM->IDLE; rdn=1, wrn=1, uart_doe=0, uart_dout=0, busy=0.
  - FIFOs emptied: tx_ready=1, rx_valid=0, levels=0.
  - Synchroniser flops cleared to 0.
  - Reset mid-cycle abandons the cycle; strobes return to 1 on the same edge.
- tbre, tsre, data_ready each pass a 2-flop synchroniser (tbre_s, tsre_s, dr_s). Only synced values are used.
- FIFO write/read:
  - TX push on tx_valid&tx_ready.
  - RX pop on rx_valid&rx_ready.
  - Simultaneous push and pop on the same FIFO leaves level unchanged. Pop when empty, or push when full, is ignored.
  - Pointers wrap modulo depth.
  - RX FIFO is first-word-fall-through.
- FSM states: IDLE, RD_LOW, RD_DONE, WR_SETUP, WR_LOW, WR_HOLD, WR_SETTLE, WR_WAIT.
  - IDLE:
    - If dr_s=1 and RX not full -> RD_LOW. RX has priority.
    - Else if TX not empty -> WR_SETUP.
    - If RX is full, data_ready is left pending; the CPLD holds the byte, so nothing is lost.
  - RD_LOW: rdn=0 for PULSE_CYC cycles. On the last cycle, uart_din is registered into the RX FIFO. Then -> RD_DONE.
  - RD_DONE: rdn=1. Wait until dr_s=0 before returning to IDLE, which prevents a double read of one byte.
  - WR_SETUP: pop TX head into uart_dout; uart_doe=1; wrn=1. Lasts 1 cycle.
  - WR_LOW: wrn=0 for PULSE_CYC cycles; data stays stable.
  - WR_HOLD: wrn=1; uart_doe stays 1 for 1 cycle (data hold past the rising strobe).
  - WR_SETTLE: uart_doe=0; count SETTLE_CYC cycles, ignoring stale tbre/tsre.
  - WR_WAIT: when tbre_s=1 and tsre_s=1 -> IDLE. No timeout.
- rdn and wrn are never low together. uart_doe is never 1 while rdn=0.
- Latency:
  - Read: min 1 (sync) + 1 (IDLE) + PULSE_CYC + 1 cycles from data_ready to rx_valid.
  - Write: tx push to wrn fall is 1 (FIFO) + 1 (IDLE) + 1 (WR_SETUP) cycles when idle.
- A tx push during a read is queued; it is serviced after RD_DONE.

Decomposition:
- Package uart_cpld_pkg holds:
  - the FSM state enum (3-bit encoding);
  - the strobe-inactive constant (1'b1);
  - a clog2 helper function.
- One sub-module, sync_fifo (params WIDTH, DEPTH; ports push/pop/full/empty/level/dout), is instantiated twice for TX and RX.
- The 2-flop synchronisers are inline.

Test Plan:
- Reset: hold rst=0 with tx_valid=1 and data_ready=1 -> rdn=wrn=1, uart_doe=0, tx_level=0, rx_valid=0. After release, the first wrn fall occurs 3 cycles after the tx push.
- Single write: push 0x5A; model tbre/tsre dropping for 20 cycles -> uart_dout=0x5A with doe=1 from 1 cycle before until 1 cycle after the wrn low pulse of PULSE_CYC=2 cycles. FSM is IDLE only after tbre=tsre=1.
- Single read: data_ready=1 with uart_din=0xC3; model drops data_ready 2 cycles after rdn falls -> one rdn pulse of 2 cycles, rx_data=0xC3, rx_valid=1, rx_level=1, no second read.
- RX full backpressure: rx_ready=0 with RX_DEPTH=4; model provides 5 bytes 0x01..0x05 -> exactly 4 reads, data_ready stays pending. One pop triggers the 5th read; order is 0x01..0x05.
- Arbitration: data_ready rises in the same cycle as a pending TX byte 0xAA -> read completes first, then the write. wrn and rdn are never low together (assertion).
- TX wrap: push 9 bytes 0x10..0x18 with TX_DEPTH=4, observing tx_ready stalls -> all 9 appear on uart_dout in order, with pointer wrap exercised twice.
